// File: rtl/alu_exec_unit_pkg.sv
// Shared encodings for the ALU issue port: operand selects and funct3 codes
// for both the arithmetic ops and the conditional-branch comparisons.
package alu_exec_unit_pkg;

    typedef enum logic [1:0] {
        ALU_SEL_A_RS1  = 2'd0,
        ALU_SEL_A_PC   = 2'd1,
        ALU_SEL_A_ZERO = 2'd2,
        ALU_SEL_A_RSVD = 2'd3
    } alu_sel_a_t;

    typedef enum logic [1:0] {
        ALU_SEL_B_RS2  = 2'd0,
        ALU_SEL_B_IMM  = 2'd1,
        ALU_SEL_B_FOUR = 2'd2,
        ALU_SEL_B_RSVD = 2'd3
    } alu_sel_b_t;

    localparam logic [2:0] FUNC3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNC3_SLL     = 3'b001;
    localparam logic [2:0] FUNC3_SLT     = 3'b010;
    localparam logic [2:0] FUNC3_SLTU    = 3'b011;
    localparam logic [2:0] FUNC3_XOR     = 3'b100;
    localparam logic [2:0] FUNC3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNC3_OR      = 3'b110;
    localparam logic [2:0] FUNC3_AND     = 3'b111;

    localparam logic [2:0] FUNC3_BEQ  = 3'b000;
    localparam logic [2:0] FUNC3_BNE  = 3'b001;
    localparam logic [2:0] FUNC3_BLT  = 3'b100;
    localparam logic [2:0] FUNC3_BGE  = 3'b101;
    localparam logic [2:0] FUNC3_BLTU = 3'b110;
    localparam logic [2:0] FUNC3_BGEU = 3'b111;

endpackage

// File: rtl/alu_exec_unit_branch_resolve.sv
// Combinational control-flow resolution: branch condition, jump/branch target,
// the architecturally correct next PC and whether the front end guessed it.
module branch_resolve
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int PC_WIDTH = 64,
    parameter int IMM_LEN  = 32
) (
    input  logic [XLEN-1:0]     rs1,
    input  logic [XLEN-1:0]     rs2,
    input  logic [2:0]          func3,
    input  logic                branch,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] pc,
    input  logic [IMM_LEN-1:0]  imm,
    input  logic [PC_WIDTH-1:0] next_pc,
    input  logic [PC_WIDTH-1:0] predict_pc,
    input  logic [XLEN-1:0]     sum,
    output logic                taken,
    output logic [PC_WIDTH-1:0] actual_next_pc,
    output logic                mispredict
);

    logic                cond;
    logic [PC_WIDTH-1:0] imm_ext;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;
    logic [PC_WIDTH-1:0] target;

    assign imm_ext       = {{(PC_WIDTH-IMM_LEN){imm[IMM_LEN-1]}}, imm};
    assign branch_target = pc + imm_ext;
    // JALR requires bit 0 cleared; JAL targets are already even so the mask is harmless.
    assign jump_target   = PC_WIDTH'(sum) & ~PC_WIDTH'(1);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cond = 1'b0;
        case (func3)
            FUNC3_BEQ:  cond = (rs1 == rs2);
            FUNC3_BNE:  cond = (rs1 != rs2);
            FUNC3_BLT:  cond = ($signed(rs1) <  $signed(rs2));
            FUNC3_BGE:  cond = ($signed(rs1) >= $signed(rs2));
            FUNC3_BLTU: cond = (rs1 <  rs2);
            FUNC3_BGEU: cond = (rs1 >= rs2);
            default:    cond = 1'b0;
        endcase
    end

    // Jump wins if both are ever raised together.
    assign taken          = jump | (branch & cond);
    assign target         = jump ? jump_target : branch_target;
    assign actual_next_pc = taken ? target : next_pc;
    assign mispredict     = (actual_next_pc != predict_pc);

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle integer execute unit for one ALU issue port: RV64I/RV64I-W ALU,
// branch/jump resolution and a registered writeback/redirect bundle.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int XLEN               = 64,
    parameter int PC_WIDTH           = 64,
    parameter int IMM_LEN            = 32,
    parameter int ROB_INDEX_WIDTH    = 4,
    parameter int PHY_REG_ADDR_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    input  logic [ROB_INDEX_WIDTH-1:0]    robID_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0] prd_i,
    input  logic [2:0]                    func3_i,
    input  logic                          func_modifier_i,
    input  logic [1:0]                    select_a_i,
    input  logic [1:0]                    select_b_i,
    input  logic                          half_i,
    input  logic                          jump_i,
    input  logic                          branch_i,
    input  logic [PC_WIDTH-1:0]           pc_i,
    input  logic [PC_WIDTH-1:0]           next_pc_i,
    input  logic [PC_WIDTH-1:0]           predict_pc_i,
    input  logic [IMM_LEN-1:0]            imm_data_i,
    input  logic [XLEN-1:0]               rs1_data_i,
    input  logic [XLEN-1:0]               rs2_data_i,
    input  logic                          flush_i,
    output logic                          done_valid_o,
    output logic                          wb_en_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_o,
    output logic [XLEN-1:0]               wb_data_o,
    output logic [ROB_INDEX_WIDTH-1:0]    wb_robID_o,
    output logic                          branch_taken_o,
    output logic                          mispredict_o,
    output logic [PC_WIDTH-1:0]           redirect_pc_o
);

    alu_sel_a_t sel_a;
    alu_sel_b_t sel_b;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] sum;

    assign sel_a   = alu_sel_a_t'(select_a_i);
    assign sel_b   = alu_sel_b_t'(select_b_i);
    assign imm_ext = {{(XLEN-IMM_LEN){imm_data_i[IMM_LEN-1]}}, imm_data_i};

    always_comb begin
        op_a = '0;
        case (sel_a)
            ALU_SEL_A_RS1: op_a = rs1_data_i;
            ALU_SEL_A_PC:  op_a = XLEN'(pc_i);
            default:       op_a = '0;
        endcase
    end

    always_comb begin
        op_b = '0;
        case (sel_b)
            ALU_SEL_B_RS2:  op_b = rs2_data_i;
            ALU_SEL_B_IMM:  op_b = imm_ext;
            ALU_SEL_B_FOUR: op_b = XLEN'(4);
            default:        op_b = '0;
        endcase
    end

    assign sum = op_a + op_b;

    // Full-width datapath.
    logic [5:0]             shamt_d;
    logic signed [XLEN-1:0] sra_d;
    logic [XLEN-1:0]        res_d;

    assign shamt_d = op_b[5:0];
    // Kept as its own signal so the arithmetic shift is never dragged unsigned by a mux.
    assign sra_d   = $signed(op_a) >>> shamt_d;

    always_comb begin
        res_d = '0;
        case (func3_i)
            FUNC3_ADD_SUB: res_d = func_modifier_i ? (op_a - op_b) : sum;
            FUNC3_SLL:     res_d = op_a << shamt_d;
            FUNC3_SLT:     res_d = XLEN'($signed(op_a) < $signed(op_b));
            FUNC3_SLTU:    res_d = XLEN'(op_a < op_b);
            FUNC3_XOR:     res_d = op_a ^ op_b;
            FUNC3_SRL_SRA: res_d = func_modifier_i ? XLEN'(sra_d) : (op_a >> shamt_d);
            FUNC3_OR:      res_d = op_a | op_b;
            FUNC3_AND:     res_d = op_a & op_b;
            default:       res_d = '0;
        endcase
    end

    // 32-bit W datapath; result is sign-extended from bit 31.
    logic [31:0]        a_w;
    logic [31:0]        b_w;
    logic [4:0]         shamt_w;
    logic signed [31:0] sra_w;
    logic [31:0]        res_w;

    assign a_w     = op_a[31:0];
    assign b_w     = op_b[31:0];
    assign shamt_w = op_b[4:0];
    assign sra_w   = $signed(a_w) >>> shamt_w;

    always_comb begin
        res_w = '0;
        case (func3_i)
            FUNC3_ADD_SUB: res_w = func_modifier_i ? (a_w - b_w) : (a_w + b_w);
            FUNC3_SLL:     res_w = a_w << shamt_w;
            FUNC3_SLT:     res_w = 32'($signed(a_w) < $signed(b_w));
            FUNC3_SLTU:    res_w = 32'(a_w < b_w);
            FUNC3_XOR:     res_w = a_w ^ b_w;
            FUNC3_SRL_SRA: res_w = func_modifier_i ? 32'(sra_w) : (a_w >> shamt_w);
            FUNC3_OR:      res_w = a_w | b_w;
            FUNC3_AND:     res_w = a_w & b_w;
            default:       res_w = '0;
        endcase
    end

    logic [XLEN-1:0] alu_result;
    assign alu_result = half_i ? {{(XLEN-32){res_w[31]}}, res_w} : res_d;

    logic                taken;
    logic [PC_WIDTH-1:0] actual_next_pc;
    logic                mispredict;

    branch_resolve #(
        .XLEN     (XLEN),
        .PC_WIDTH (PC_WIDTH),
        .IMM_LEN  (IMM_LEN)
    ) u_branch_resolve (
        .rs1            (rs1_data_i),
        .rs2            (rs2_data_i),
        .func3          (func3_i),
        .branch         (branch_i),
        .jump           (jump_i),
        .pc             (pc_i),
        .imm            (imm_data_i),
        .next_pc        (next_pc_i),
        .predict_pc     (predict_pc_i),
        .sum            (sum),
        .taken          (taken),
        .actual_next_pc (actual_next_pc),
        .mispredict     (mispredict)
    );

    logic            wb_en_next;
    logic [XLEN-1:0] wb_data_next;

    assign wb_en_next   = jump_i | ~branch_i;
    assign wb_data_next = jump_i   ? XLEN'(next_pc_i) :
                          branch_i ? '0               : alu_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            done_valid_o   <= 1'b0;
            wb_en_o        <= 1'b0;
            wb_prd_o       <= '0;
            wb_data_o      <= '0;
            wb_robID_o     <= '0;
            branch_taken_o <= 1'b0;
            mispredict_o   <= 1'b0;
            redirect_pc_o  <= '0;
        end else if (req_valid_i && !flush_i) begin
            done_valid_o   <= 1'b1;
            wb_en_o        <= wb_en_next;
            wb_prd_o       <= prd_i;
            wb_data_o      <= wb_data_next;
            wb_robID_o     <= robID_i;
            branch_taken_o <= taken;
            mispredict_o   <= mispredict;
            redirect_pc_o  <= actual_next_pc;
        end else begin
            // Data fields may hold stale values; only the qualifiers must drop.
            done_valid_o   <= 1'b0;
            wb_en_o        <= 1'b0;
            mispredict_o   <= 1'b0;
        end
    end

    jump_branch_exclusive: assert property (
        @(posedge clk) disable iff (rst) req_valid_i |-> !(jump_i && branch_i)
    );

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, hand-written
// flush/reset sequences and randomized traffic against a behavioural model.
module tb_alu_exec_unit;

    typedef struct {
        logic [2:0]  func3;
        logic        mod;
        logic [1:0]  sa;
        logic [1:0]  sb;
        logic        half;
        logic        jump;
        logic        branch;
        logic [63:0] rs1;
        logic [63:0] rs2;
        logic [31:0] imm;
        logic [63:0] pc;
        logic [63:0] next_pc;
        logic [63:0] predict_pc;
        logic [5:0]  prd;
        logic [3:0]  rob;
    } req_t;

    typedef struct {
        logic        wb_en;
        logic [63:0] wb_data;
        logic        taken;
        logic        mispredict;
        logic [63:0] redirect;
    } exp_t;

    typedef struct {
        string name;
        req_t  req;
        exp_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [3:0]  rob_id;
    logic [5:0]  prd;
    logic [2:0]  func3;
    logic        func_modifier;
    logic [1:0]  select_a;
    logic [1:0]  select_b;
    logic        half;
    logic        jump;
    logic        branch;
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic [63:0] predict_pc;
    logic [31:0] imm_data;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        flush;

    logic        done_valid;
    logic        wb_en;
    logic [5:0]  wb_prd;
    logic [63:0] wb_data;
    logic [3:0]  wb_rob_id;
    logic        branch_taken;
    logic        mispredict;
    logic [63:0] redirect_pc;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid),
        .robID_i         (rob_id),
        .prd_i           (prd),
        .func3_i         (func3),
        .func_modifier_i (func_modifier),
        .select_a_i      (select_a),
        .select_b_i      (select_b),
        .half_i          (half),
        .jump_i          (jump),
        .branch_i        (branch),
        .pc_i            (pc),
        .next_pc_i       (next_pc),
        .predict_pc_i    (predict_pc),
        .imm_data_i      (imm_data),
        .rs1_data_i      (rs1_data),
        .rs2_data_i      (rs2_data),
        .flush_i         (flush),
        .done_valid_o    (done_valid),
        .wb_en_o         (wb_en),
        .wb_prd_o        (wb_prd),
        .wb_data_o       (wb_data),
        .wb_robID_o      (wb_rob_id),
        .branch_taken_o  (branch_taken),
        .mispredict_o    (mispredict),
        .redirect_pc_o   (redirect_pc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    function automatic req_t mk_req(
        input logic [2:0] f3, input logic md, input logic [1:0] sa, input logic [1:0] sb,
        input logic hf, input logic jp, input logic br,
        input logic [63:0] r1, input logic [63:0] r2, input logic [31:0] im,
        input logic [63:0] p, input logic [63:0] np, input logic [63:0] pp);
        req_t r;
        r.func3 = f3; r.mod = md; r.sa = sa; r.sb = sb; r.half = hf;
        r.jump = jp; r.branch = br; r.rs1 = r1; r.rs2 = r2; r.imm = im;
        r.pc = p; r.next_pc = np; r.predict_pc = pp; r.prd = 6'd0; r.rob = 4'd0;
        return r;
    endfunction

    function automatic exp_t mk_exp(input logic en, input logic [63:0] d, input logic tk,
                                    input logic mp, input logic [63:0] rd);
        exp_t e;
        e.wb_en = en; e.wb_data = d; e.taken = tk; e.mispredict = mp; e.redirect = rd;
        return e;
    endfunction

    // Reference model: RISC-V semantics evaluated with native signed/unsigned integer arithmetic.
    function automatic exp_t model(input req_t r);
        exp_t   e;
        longint a, b, res;
        int     a32, b32, r32, sh;
        logic   cond;
        case (r.sa)
            2'd0:    a = longint'(r.rs1);
            2'd1:    a = longint'(r.pc);
            default: a = 0;
        endcase
        case (r.sb)
            2'd0:    b = longint'(r.rs2);
            2'd1:    b = longint'(int'(r.imm));
            2'd2:    b = 4;
            default: b = 0;
        endcase
        if (r.half) begin
            a32 = int'(a);
            b32 = int'(b);
            sh  = b32 & 31;
            case (r.func3)
                3'd0:    r32 = r.mod ? a32 - b32 : a32 + b32;
                3'd1:    r32 = a32 << sh;
                3'd2:    r32 = (a32 < b32) ? 1 : 0;
                3'd3:    r32 = (unsigned'(a32) < unsigned'(b32)) ? 1 : 0;
                3'd4:    r32 = a32 ^ b32;
                3'd5:    r32 = r.mod ? (a32 >>> sh) : int'(unsigned'(a32) >> sh);
                3'd6:    r32 = a32 | b32;
                default: r32 = a32 & b32;
            endcase
            res = longint'(r32);
        end else begin
            sh = int'(b & 63);
            case (r.func3)
                3'd0:    res = r.mod ? a - b : a + b;
                3'd1:    res = a << sh;
                3'd2:    res = (a < b) ? 1 : 0;
                3'd3:    res = (unsigned'(a) < unsigned'(b)) ? 1 : 0;
                3'd4:    res = a ^ b;
                3'd5:    res = r.mod ? (a >>> sh) : longint'(unsigned'(a) >> sh);
                3'd6:    res = a | b;
                default: res = a & b;
            endcase
        end
        e.wb_en    = 1'b1;
        e.wb_data  = res;
        e.taken    = 1'b0;
        e.redirect = r.next_pc;
        if (r.jump) begin
            e.taken    = 1'b1;
            e.redirect = (a + b) & ~longint'(1);
            e.wb_data  = r.next_pc;
        end else if (r.branch) begin
            case (r.func3)
                3'd0:    cond = (r.rs1 == r.rs2);
                3'd1:    cond = (r.rs1 != r.rs2);
                3'd4:    cond = (longint'(r.rs1) <  longint'(r.rs2));
                3'd5:    cond = (longint'(r.rs1) >= longint'(r.rs2));
                3'd6:    cond = (r.rs1 <  r.rs2);
                3'd7:    cond = (r.rs1 >= r.rs2);
                default: cond = 1'b0;
            endcase
            e.taken   = cond;
            e.wb_en   = 1'b0;
            e.wb_data = '0;
            if (cond) e.redirect = r.pc + 64'(longint'(int'(r.imm)));
        end
        e.mispredict = (e.redirect != r.predict_pc);
        return e;
    endfunction

    task automatic drive(input req_t r, input logic valid, input logic fl);
        req_valid = valid; flush = fl;
        func3 = r.func3; func_modifier = r.mod; select_a = r.sa; select_b = r.sb;
        half = r.half; jump = r.jump; branch = r.branch;
        rs1_data = r.rs1; rs2_data = r.rs2; imm_data = r.imm;
        pc = r.pc; next_pc = r.next_pc; predict_pc = r.predict_pc;
        prd = r.prd; rob_id = r.rob;
    endtask

    task automatic check_valid(input string tag, input req_t r, input exp_t e);
        check({tag, ".done_valid"}, 64'(done_valid),   64'd1);
        check({tag, ".wb_en"},      64'(wb_en),        64'(e.wb_en));
        check({tag, ".wb_prd"},     64'(wb_prd),       64'(r.prd));
        check({tag, ".wb_robID"},   64'(wb_rob_id),    64'(r.rob));
        check({tag, ".wb_data"},    wb_data,           e.wb_data);
        check({tag, ".taken"},      64'(branch_taken), 64'(e.taken));
        check({tag, ".redirect"},   redirect_pc,       e.redirect);
        check({tag, ".mispredict"}, 64'(mispredict),   64'(e.mispredict));
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".done_valid"}, 64'(done_valid), 64'd0);
        check({tag, ".wb_en"},      64'(wb_en),      64'd0);
        check({tag, ".mispredict"}, 64'(mispredict), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_idle(tag);
        check({tag, ".wb_prd"},   64'(wb_prd),       64'd0);
        check({tag, ".wb_data"},  wb_data,           64'd0);
        check({tag, ".wb_robID"}, 64'(wb_rob_id),    64'd0);
        check({tag, ".taken"},    64'(branch_taken), 64'd0);
        check({tag, ".redirect"}, redirect_pc,       64'd0);
    endtask

    vec_t vecs[18];
    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    initial begin
        req_t  r;
        exp_t  e;
        logic  v, f;

        vecs[0]  = '{"add",     mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'd5, 64'd7, 32'd0, 64'h100, 64'h104, 64'h104),
                               mk_exp(1, 64'd12, 0, 0, 64'h104)};
        vecs[1]  = '{"sraw",    mk_req(3'd5,1,2'd0,2'd1,1,0,0, 64'h8000_0000, 64'd0, 32'd4, 64'h200, 64'h204, 64'h204),
                               mk_exp(1, 64'hFFFF_FFFF_F800_0000, 0, 0, 64'h204)};
        vecs[2]  = '{"blt",     mk_req(3'd4,0,2'd1,2'd1,0,0,1, M1, 64'd1, 32'h40, 64'h1000, 64'h1004, 64'h1004),
                               mk_exp(0, 64'd0, 1, 1, 64'h1040)};
        vecs[3]  = '{"jalr",    mk_req(3'd0,0,2'd0,2'd1,0,1,0, 64'h2003, 64'd0, 32'h10, 64'h3000, 64'h3004, 64'h2012),
                               mk_exp(1, 64'h3004, 1, 0, 64'h2012)};
        vecs[4]  = '{"sub_wrap",mk_req(3'd0,1,2'd0,2'd0,0,0,0, 64'd0, 64'd1, 32'd0, 64'h300, 64'h304, 64'h500),
                               mk_exp(1, M1, 0, 1, 64'h304)};
        vecs[5]  = '{"sltu",    mk_req(3'd3,0,2'd0,2'd0,0,0,0, 64'd1, M1, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'd1, 0, 0, 64'h4)};
        vecs[6]  = '{"slt",     mk_req(3'd2,0,2'd0,2'd0,0,0,0, 64'd1, M1, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'd0, 0, 0, 64'h4)};
        vecs[7]  = '{"sll63",   mk_req(3'd1,0,2'd0,2'd0,0,0,0, 64'd1, 64'd127, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'h8000_0000_0000_0000, 0, 0, 64'h4)};
        vecs[8]  = '{"sllw31",  mk_req(3'd1,0,2'd0,2'd0,1,0,0, 64'd1, 64'd63, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'hFFFF_FFFF_8000_0000, 0, 0, 64'h4)};
        vecs[9]  = '{"addiw",   mk_req(3'd0,0,2'd0,2'd1,1,0,0, 64'hFFFF_FFFF_0000_0005, 64'd0, 32'hFFFF_FFFF, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'd4, 0, 0, 64'h4)};
        vecs[10] = '{"beq_nt",  mk_req(3'd0,0,2'd1,2'd1,0,0,1, 64'd3, 64'd4, 32'h40, 64'h1000, 64'h1004, 64'h1004),
                               mk_exp(0, 64'd0, 0, 0, 64'h1004)};
        vecs[11] = '{"br_f010", mk_req(3'd2,0,2'd1,2'd1,0,0,1, 64'd9, 64'd9, 32'h40, 64'h1000, 64'h1004, 64'h1040),
                               mk_exp(0, 64'd0, 0, 1, 64'h1004)};
        vecs[12] = '{"bgeu_neg",mk_req(3'd7,0,2'd1,2'd1,0,0,1, M1, 64'd1, 32'hFFFF_FFF0, 64'h1000, 64'h1004, 64'h0FF0),
                               mk_exp(0, 64'd0, 1, 0, 64'h0FF0)};
        vecs[13] = '{"jal",     mk_req(3'd0,0,2'd1,2'd1,0,1,0, 64'd0, 64'd0, 32'h100, 64'h4000, 64'h4004, 64'h4000),
                               mk_exp(1, 64'h4004, 1, 1, 64'h4100)};
        vecs[14] = '{"selA3_B4",mk_req(3'd0,0,2'd3,2'd2,0,0,0, 64'h55, 64'h66, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'd4, 0, 0, 64'h4)};
        vecs[15] = '{"or_selB3",mk_req(3'd6,0,2'd0,2'd3,0,0,0, 64'h1234, 64'hFFFF, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'h1234, 0, 0, 64'h4)};
        vecs[16] = '{"auipc",   mk_req(3'd0,0,2'd1,2'd1,0,0,0, 64'd0, 64'd0, 32'h1000, 64'h8000, 64'h8004, 64'h8004),
                               mk_exp(1, 64'h9000, 0, 0, 64'h8004)};
        vecs[17] = '{"srl",     mk_req(3'd5,0,2'd0,2'd0,0,0,0, 64'h8000_0000_0000_0000, 64'd4, 32'd0, 64'h0, 64'h4, 64'h4),
                               mk_exp(1, 64'h0800_0000_0000_0000, 0, 0, 64'h4)};

        r = mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'd0, 64'd0, 32'd0, 64'h0, 64'h4, 64'h4);
        drive(r, 1'b1, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");

        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 18; i++) begin
            r = vecs[i].req;
            r.prd = 6'(i + 10);
            r.rob = 4'(i);
            drive(r, 1'b1, 1'b0);
            @(posedge clk); #1;
            check_valid(vecs[i].name, r, vecs[i].exp);
            @(negedge clk);
        end

        // Flush: visible result stays put, flushed request vanishes, next request lands.
        r = mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'd1, 64'd2, 32'd0, 64'h10, 64'h14, 64'h14);
        r.prd = 6'd5; r.rob = 4'd5;
        drive(r, 1'b1, 1'b0);
        @(posedge clk); #1 check_valid("pre_flush", r, mk_exp(1, 64'd3, 0, 0, 64'h14));
        @(negedge clk);
        r = mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'd7, 64'd8, 32'd0, 64'h20, 64'h24, 64'h90);
        drive(r, 1'b1, 1'b1);
        #1 check("flush_cycle_n.done_valid", 64'(done_valid), 64'd1);
        @(posedge clk); #1 check_idle("flushed");
        @(negedge clk);
        r = mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'd10, 64'd20, 32'd0, 64'h30, 64'h34, 64'h34);
        r.prd = 6'd6; r.rob = 4'd6;
        drive(r, 1'b1, 1'b0);
        @(posedge clk); #1 check_valid("post_flush", r, mk_exp(1, 64'd30, 0, 0, 64'h34));

        // Reset mid-stream after a mispredicted branch, then an 8-deep back-to-back burst.
        @(negedge clk);
        r = vecs[2].req; r.prd = 6'd9; r.rob = 4'd9;
        drive(r, 1'b1, 1'b0);
        @(posedge clk); #1 check_valid("pre_rst", r, vecs[2].exp);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 check_all_zero("mid_rst");
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            r = mk_req(3'd0,0,2'd0,2'd0,0,0,0, 64'(i*100), 64'(i), 32'd0, 64'h0, 64'h4, 64'h4);
            r.prd = 6'(i + 1); r.rob = 4'(i);
            drive(r, 1'b1, 1'b0);
            @(posedge clk); #1;
            check($sformatf("burst%0d.done_valid", i), 64'(done_valid), 64'd1);
            check($sformatf("burst%0d.wb_robID", i),   64'(wb_rob_id),  64'(i));
            check($sformatf("burst%0d.wb_data", i),    wb_data,         64'(i*101));
            @(negedge clk);
        end

        // Randomized traffic, one request per cycle, against the model.
        for (int i = 0; i < 400; i++) begin
            int kind;
            r.func3  = 3'($urandom);
            r.mod    = 1'($urandom);
            r.sa     = 2'($urandom);
            r.sb     = 2'($urandom);
            r.half   = 1'($urandom);
            kind     = int'($urandom_range(0, 3));
            r.jump   = (kind == 3);
            r.branch = (kind == 2);
            r.rs1    = {$urandom, $urandom};
            r.rs2    = ($urandom_range(0, 3) == 0) ? r.rs1 : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) r.rs2 = 64'($urandom_range(0, 127));
            r.imm    = $urandom;
            r.pc     = {$urandom, $urandom} & ~64'd3;
            r.next_pc = r.pc + 64'd4;
            case ($urandom_range(0, 2))
                0:       r.predict_pc = r.next_pc;
                1:       r.predict_pc = r.pc + 64'(longint'(int'(r.imm)));
                default: r.predict_pc = {$urandom, $urandom};
            endcase
            r.prd = 6'($urandom);
            r.rob = 4'($urandom);
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            drive(r, v, f);
            @(posedge clk); #1;
            if (v && !f) begin
                e = model(r);
                check_valid($sformatf("rand%0d", i), r, e);
            end else begin
                check_idle($sformatf("rand%0d_idle", i));
            end
            @(negedge clk);
        end

        req_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
